// File: rtl/sockit_spi_pkg.sv
// Shared types for the sockit SPI slave: transfer FSM states and the error-pulse bundle.
package sockit_spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic udf;
        logic ovf;
        logic abt;
    } err_t;

    localparam err_t ERR_NONE = '{udf: 1'b0, ovf: 1'b0, abt: 1'b0};

endpackage

// File: rtl/sockit_spi_syn.sv
// SYN-deep synchronizer for one asynchronous SPI pin, with rise/fall detection
// taken from the last two synchronized samples.
module sockit_spi_syn
    import sockit_spi_pkg::*;
#(
    parameter int   SYN     = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYN-1:0] sync_q;
    logic [SYN-1:0] sync_d;
    logic           prev_q;
    logic           prev_d;

    // Next-state of the chain and of the one-sample history.
    always_comb begin
        sync_d = {sync_q[SYN-2:0], d};
        prev_d = sync_q[SYN-1];
    end

    // Synchronizer flops, reset to the pin's idle level so reset creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYN{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[SYN-1];
    assign rise = sync_q[SYN-1] & ~prev_q;
    assign fall = ~sync_q[SYN-1] & prev_q;

endmodule

// File: rtl/sockit_spi_slv.sv
// SPI slave, fully clocked by the system clock: pins are oversampled, SCLK edges
// become sample/shift events, and words move through valid/ready streams.
module sockit_spi_slv
    import sockit_spi_pkg::*;
#(
    parameter int   DW   = 8,
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0,
    parameter int   SYN  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_sclk,
    input  logic          spi_ss_n,
    input  logic          spi_mosi,
    output logic          spi_miso_o,
    output logic          spi_miso_e,
    input  logic          sdw_vld,
    input  logic [DW-1:0] sdw_dat,
    output logic          sdw_rdy,
    output logic          sdr_vld,
    output logic [DW-1:0] sdr_dat,
    input  logic          sdr_rdy,
    output logic          err_udf,
    output logic          err_ovf,
    output logic          err_abt
);

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    logic sclk_lvl_unused, sclk_rise_s, sclk_fall_s;
    logic ss_s, ss_rise_s, ss_fall_s;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic lead_s, trail_s, smp_s, shf_s, load_s;
    logic [DW-1:0] word_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-2:0] rx_q, rx_d;
    logic [DW-1:0] tx_q, tx_d;
    logic          miso_e_q, miso_e_d;
    logic          sdw_rdy_q, sdw_rdy_d;
    logic          sdr_vld_q, sdr_vld_d;
    logic [DW-1:0] sdr_dat_q, sdr_dat_d;
    err_t          err_q, err_d;
    logic [SYN:0]  flush_q, flush_d;
    logic          armed_q, armed_d;

    sockit_spi_syn #(.SYN(SYN), .RST_VAL(CPOL)) u_syn_sclk (
        .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_lvl_unused), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    sockit_spi_syn #(.SYN(SYN), .RST_VAL(1'b1)) u_syn_ss (
        .clk(clk), .rst(rst), .d(spi_ss_n), .q(ss_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );
    sockit_spi_syn #(.SYN(SYN), .RST_VAL(1'b0)) u_syn_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign lead_s  = CPOL ? sclk_fall_s : sclk_rise_s;
    assign trail_s = CPOL ? sclk_rise_s : sclk_fall_s;
    assign smp_s   = CPHA ? trail_s : lead_s;
    assign shf_s   = CPHA ? lead_s : trail_s;
    assign word_s  = {rx_q, mosi_s};

    // Transfer FSM, shift registers, stream handshakes and error pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        sdw_rdy_d = 1'b0;
        sdr_vld_d = sdr_vld_q & ~sdr_rdy;
        sdr_dat_d = sdr_dat_q;
        err_d     = ERR_NONE;
        load_s    = 1'b0;
        // A select that was already low at reset release must go high before it can start a word.
        flush_d   = {flush_q[SYN-1:0], 1'b1};
        armed_d   = armed_q | (flush_q[SYN] & ss_s);
        case (state_q)
            ST_IDLE: begin
                if (ss_fall_s && armed_q) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                    rx_d    = '0;
                    load_s  = ~CPHA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (ss_rise_s) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    err_d.abt = (cnt_q != '0);
                end else if (smp_s) begin
                    rx_d = word_s[DW-2:0];
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!sdr_vld_q || sdr_rdy) begin
                            sdr_vld_d = 1'b1;
                            sdr_dat_d = word_s;
                        end else begin
                            err_d.ovf = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (shf_s) begin
                    if (cnt_q == '0) begin
                        load_s = 1'b1;
                    end else begin
                        tx_d = {tx_q[DW-2:0], 1'b0};
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_s) begin
            if (sdw_vld) begin
                tx_d      = sdw_dat;
                sdw_rdy_d = 1'b1;
            end else begin
                tx_d      = '1;
                err_d.udf = 1'b1;
            end
        end else begin
            sdw_rdy_d = 1'b0;
        end
        miso_e_d = (state_d == ST_XFER);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_e_q  <= 1'b0;
            sdw_rdy_q <= 1'b0;
            sdr_vld_q <= 1'b0;
            sdr_dat_q <= '0;
            err_q     <= ERR_NONE;
            flush_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_e_q  <= miso_e_d;
            sdw_rdy_q <= sdw_rdy_d;
            sdr_vld_q <= sdr_vld_d;
            sdr_dat_q <= sdr_dat_d;
            err_q     <= err_d;
            flush_q   <= flush_d;
            armed_q   <= armed_d;
        end
    end

    assign spi_miso_e = miso_e_q;
    assign spi_miso_o = miso_e_q & tx_q[DW-1];
    assign sdw_rdy    = sdw_rdy_q;
    assign sdr_vld    = sdr_vld_q;
    assign sdr_dat    = sdr_dat_q;
    assign err_udf    = err_q.udf;
    assign err_ovf    = err_q.ovf;
    assign err_abt    = err_q.abt;

endmodule

// File: doc/sockit_spi_slv.md
SOCKIT_SPI_SLV -- requirements
Module: sockit_spi_slv

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the serial word width in bits (range 4..32).
REQ-002 SHALL have parameter CPOL, default 1'b0, meaning the SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 1'b0, meaning 0 = sample on leading edge and 1 = sample on trailing edge.
REQ-004 SHALL have parameter SYN, default 2, meaning the input synchronizer depth in flops (minimum 2).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port spi_sclk, input, 1 bit: SPI clock from the master; asynchronous to clk.
REQ-008 SHALL have port spi_ss_n, input, 1 bit: slave select, active-low, asynchronous.
REQ-009 SHALL have port spi_mosi, input, 1 bit: serial data from the master.
REQ-010 SHALL have port spi_miso_o, output, 1 bit: serial data to the master.
REQ-011 SHALL have port spi_miso_e, output, 1 bit: MISO output enable for the tristate pad.
REQ-012 SHALL have ports sdw_vld (input, 1), sdw_dat (input, DW) and sdw_rdy (output, 1): the transmit word stream.
REQ-013 SHALL have ports sdr_vld (output, 1), sdr_dat (output, DW) and sdr_rdy (input, 1): the receive word stream.
REQ-014 SHALL have ports err_udf, err_ovf and err_abt, outputs, 1 bit each: one-clk pulses for underflow, overflow and abort.

Function
REQ-015 spi_sclk, spi_ss_n and spi_mosi SHALL each pass through SYN flops; edges SHALL be detected by comparing the last two synchronized samples.
REQ-016 The block SHALL operate correctly for any clk frequency of at least 8x the SCLK frequency; slower clk is unsupported.
REQ-017 The FSM SHALL have two states: IDLE and XFER.
REQ-018 IDLE->XFER SHALL occur on a synchronized ss_n falling edge; XFER->IDLE SHALL occur on a synchronized ss_n rising edge.
REQ-019 A sample event SHALL be the leading SCLK edge when CPHA=0 and the trailing edge when CPHA=1; a shift event SHALL be the opposite edge.
REQ-020 On each sample event, the synchronized MOSI SHALL be shifted into the rx shift register MSB-first and the bit counter SHALL increment modulo DW.
REQ-021 On each shift event, the tx shift register SHALL advance one bit and spi_miso_o SHALL present its new MSB.
REQ-022 Tx word load points: for CPHA=0, at entry to XFER and at the shift event following the DW-th sample; for CPHA=1, at the first shift event of each word.
REQ-023 At a load point with sdw_vld=1, the block SHALL load sdw_dat and assert sdw_rdy for exactly that one clk; sdw_rdy SHALL be 0 at all other times.
REQ-024 At a load point with sdw_vld=0, the block SHALL load all-ones and pulse err_udf.
REQ-025 On the DW-th sample event, if sdr_vld=0, the block SHALL copy the completed word to sdr_dat and set sdr_vld on the next clk.
REQ-026 If sdr_vld=1 at that point, the block SHALL drop the new word, leave sdr_dat unchanged and pulse err_ovf.
REQ-027 sdr_vld SHALL clear on the clk after sdr_vld&sdr_rdy.
REQ-028 If a transfer completes in the same clk that sdr_vld&sdr_rdy occurs, the new word SHALL be accepted and there SHALL be no overflow.
REQ-029 spi_miso_e SHALL be 1 only in XFER; spi_miso_o SHALL be 0 when spi_miso_e=0.
REQ-030 An ss_n rising edge with bit counter != 0 SHALL discard the partial word (no sdr output), pulse err_abt and reset the counter.
REQ-031 SCLK edges while in IDLE SHALL be ignored.
REQ-032 An ss_n rising edge and an SCLK edge detected in the same clk SHALL resolve as ss_n first, so the SCLK edge is ignored.

Reset
REQ-033 While rst=1, the block SHALL be in IDLE, with the bit counter 0, shift registers 0 and synchronizers at their idle values (sclk=CPOL, ss_n=1, mosi=0).
REQ-034 While rst=1, all outputs SHALL be 0.
REQ-035 Reset asserted mid-transfer SHALL abandon the word without an err_abt pulse.
REQ-036 After reset release, no transfer SHALL start until a fresh ss_n falling edge is seen.

Structure
REQ-037 The FSM state enum and the error-flag struct SHALL be in sockit_spi_pkg.
REQ-038 The SYN-deep synchronizer plus edge detector SHALL be the sub-module sockit_spi_syn, instantiated three times.
REQ-039 No other sub-modules SHALL be used.

Verification
REQ-040 Mode 0, DW=8, sdw_dat=0xA5 preloaded, master sends 0x3C -> master receives 0xA5, sdr_dat=0x3C, sdr_vld=1, one sdw_rdy pulse.
REQ-041 Mode 3, two back-to-back words 0x12, 0x34 with sdw queued 0x56, 0x78 -> sdr yields 0x12 then 0x34, MISO carries 0x56 then 0x78, no errors.
REQ-042 sdw_vld=0 for the whole transfer -> MISO=0xFF, err_udf pulses once per word.
REQ-043 sdr_rdy=0 held across two words 0x11, 0x22 -> sdr_dat stays 0x11, err_ovf pulses once.
REQ-044 ss_n deasserted after 5 bits -> err_abt pulses, no sdr_vld, spi_miso_e=0; the next full word 0x99 is received correctly.
REQ-045 rst asserted after 3 bits, then released, then a full transfer -> all outputs 0 during reset, no err pulses, and the following word is received correctly.
